// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; fixed WIDTH+1 edge latency.
// Quotient goes to LO, remainder to HI.
module div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   localparam int unsigned LAST_ITER = WIDTH - 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sgn_q, sgn_d;
   logic               dvd_neg_q, dvd_neg_d;
   logic               dvs_neg_q, dvs_neg_d;
   logic               dvs_zero_q, dvs_zero_d;
   logic [WIDTH-1:0]   dvd_orig_q, dvd_orig_d;
   logic [WIDTH-1:0]   dvs_mag_q, dvs_mag_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   q_res_q, q_res_d;
   logic [WIDTH-1:0]   r_res_q, r_res_d;

   logic [WIDTH:0]     shifted_c;
   logic [WIDTH:0]     trial_c;

   // One restoring step: shifted partial remainder minus divisor magnitude.
   assign shifted_c = {rem_q, quo_q[WIDTH-1]};
   assign trial_c   = shifted_c - {1'b0, dvs_mag_q};

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sgn_q      <= 1'b0;
         dvd_neg_q  <= 1'b0;
         dvs_neg_q  <= 1'b0;
         dvs_zero_q <= 1'b0;
         dvd_orig_q <= '0;
         dvs_mag_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         q_res_q    <= '0;
         r_res_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sgn_q      <= sgn_d;
         dvd_neg_q  <= dvd_neg_d;
         dvs_neg_q  <= dvs_neg_d;
         dvs_zero_q <= dvs_zero_d;
         dvd_orig_q <= dvd_orig_d;
         dvs_mag_q  <= dvs_mag_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         q_res_q    <= q_res_d;
         r_res_q    <= r_res_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sgn_d      = sgn_q;
      dvd_neg_d  = dvd_neg_q;
      dvs_neg_d  = dvs_neg_q;
      dvs_zero_d = dvs_zero_q;
      dvd_orig_d = dvd_orig_q;
      dvs_mag_d  = dvs_mag_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      q_res_d    = q_res_q;
      r_res_d    = r_res_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sgn_d      = sign;
               dvd_neg_d  = sign & dividend[WIDTH-1];
               dvs_neg_d  = sign & divisor[WIDTH-1];
               dvs_zero_d = (divisor == '0);
               dvd_orig_d = dividend;
               quo_d      = (sign & dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
               dvs_mag_d  = (sign & divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
               rem_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = S_CALC;
            end
         end

         S_CALC: begin
            if (!trial_c[WIDTH]) begin
               rem_d = trial_c[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted_c[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LAST_ITER)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            // Divide-by-zero bypasses the sign fixup entirely.
            if (dvs_zero_q) begin
               q_res_d = '1;
               r_res_d = dvd_orig_q;
            end else begin
               q_res_d = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? (~quo_q + WIDTH'(1)) : quo_q;
               r_res_d = dvd_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign q    = q_res_q;
   assign r    = r_res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;

   int n_cmp;
   int n_err;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sign     (sign),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .r        (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, truncating toward zero in signed mode.
   task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] qe, output logic [31:0] re);
      longint sa, sb, sq, sr;
      if (b == 32'd0) begin
         qe = 32'hFFFF_FFFF;
         re = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         sq = sa / sb;
         sr = sa % sb;
         qe = sq[31:0];
         re = sr[31:0];
      end else begin
         qe = a / b;
         re = a % b;
      end
   endtask

   // Issue one division; report result, edges to done, busy cycles and q/r hold violations.
   task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] qo, output logic [31:0] ro,
                          output int lat, output int bcnt, output bit hold_bad);
      logic [31:0] q0, r0;
      int k;
      @(negedge clk);
      sign = s; dividend = a; divisor = b; start = 1'b1;
      q0 = q; r0 = r;
      @(posedge clk);
      #1;
      start = 1'b0;
      sign = 1'($urandom); dividend = $urandom; divisor = $urandom;
      k = 0; bcnt = 0; hold_bad = 1'b0; lat = -1;
      while (k < 100) begin
         @(negedge clk);
         k++;
         if (done) begin
            lat = k - 1;
            break;
         end
         if (busy) bcnt++;
         if (q !== q0 || r !== r0) hold_bad = 1'b1;
      end
      qo = q; ro = r;
   endtask

   task automatic check_op(input string name, input bit s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] qo, ro, qe, re;
      int lat, bcnt;
      bit hb;
      ref_div(s, a, b, qe, re);
      run_div(s, a, b, qo, ro, lat, bcnt, hb);
      n_cmp++;
      if (qo !== qe || ro !== re || lat !== 33 || hb) begin
         n_err++;
         $display("FAIL %s: s=%0d %h/%h got q=%h r=%h lat=%0d hold_bad=%0d, want q=%h r=%h lat=33 hold_bad=0",
                  name, s, a, b, qo, ro, lat, hb, qe, re);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
         n_err++;
         $display("FAIL reset: busy=%b done=%b q=%h r=%h, want 0 0 0 0", busy, done, q, r);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned;
      logic [31:0] qo, ro;
      int lat, bcnt;
      bit hb;
      run_div(1'b0, 32'd100, 32'd7, qo, ro, lat, bcnt, hb);
      n_cmp++;
      if (qo !== 32'd14 || ro !== 32'd2) begin
         n_err++;
         $display("FAIL unsigned_100_7: q=%0d r=%0d, want 14 2", qo, ro);
      end
      n_cmp++;
      if (lat !== 33) begin
         n_err++;
         $display("FAIL latency: got %0d edges, want 33", lat);
      end
      n_cmp++;
      if (bcnt !== 33 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_window: busy cycles=%0d busy_at_done=%b, want 33 0", bcnt, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || q !== 32'd14 || r !== 32'd2) begin
         n_err++;
         $display("FAIL done_pulse_hold: done=%b q=%0d r=%0d, want 0 14 2", done, q, r);
      end
   endtask

   task automatic test_signed;
      check_op("signed_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      check_op("signed_7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      check_op("signed_neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
   endtask

   task automatic test_overflow;
      check_op("ovf_signed", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      check_op("ovf_unsigned", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_div_zero;
      check_op("dz_unsigned", 1'b0, 32'h0000_1234, 32'd0);
      check_op("dz_signed", 1'b1, 32'hFFFF_FF00, 32'd0);
   endtask

   // Start pulse mid-operation must be ignored; a start in the done cycle must be accepted.
   task automatic test_back_to_back;
      int k, lat;
      bit hold_bad;
      @(negedge clk);
      sign = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0; lat = -1;
      while (k < 100) begin
         @(negedge clk);
         k++;
         if (k == 10) begin
            dividend = 32'd9; divisor = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = k - 1;
            break;
         end
      end
      n_cmp++;
      if (q !== 32'd10 || r !== 32'd0 || lat !== 33) begin
         n_err++;
         $display("FAIL start_while_busy: q=%0d r=%0d lat=%0d, want 10 0 33", q, r, lat);
      end
      // Still in the done cycle: issue the next division.
      dividend = 32'd9; divisor = 32'd3; sign = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0; lat = -1; hold_bad = 1'b0;
      while (k < 100) begin
         @(negedge clk);
         k++;
         if (done) begin
            lat = k - 1;
            break;
         end
         if (busy !== 1'b1 || q !== 32'd10 || r !== 32'd0) hold_bad = 1'b1;
      end
      n_cmp++;
      if (hold_bad) begin
         n_err++;
         $display("FAIL start_in_done_hold: q/r left 10/0 or busy dropped before done (q=%0d r=%0d)", q, r);
      end
      n_cmp++;
      if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin
         n_err++;
         $display("FAIL start_in_done: q=%0d r=%0d lat=%0d, want 3 0 33", q, r, lat);
      end
   endtask

   task automatic test_reset_mid_op;
      int seen;
      @(negedge clk);
      sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
         n_err++;
         $display("FAIL reset_mid_op: busy=%b done=%b q=%h r=%h, want 0 0 0 0", busy, done, q, r);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (45) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL reset_no_done: saw busy/done in %0d cycles after abort, want 0", seen);
      end
      check_op("after_reset_100_7", 1'b0, 32'd100, 32'd7);
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      bit s;
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'($urandom_range(1, 15));
            1: b = 32'd0;
            2: b = 32'hFFFF_FFFF;
            3: a = 32'h8000_0000;
            4: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         check_op("random", s, a, b);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset;
      test_unsigned;
      test_signed;
      test_overflow;
      test_div_zero;
      test_back_to_back;
      test_reset_mid_op;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
